mc_main_control: RTL

Main control FSM for the multi-cycle MIPS datapath. It walks each instruction through fetch, decode, execute, memory and write-back, and drives the datapath's mux selects and write enables. It also issues the 3-bit `aluop` command to the downstream ALU decoder. Memory accesses use a ready handshake so memory can stretch any access cycle.

---
 rtl/mc_main_control_pkg.sv | 70 +++++++
 rtl/mc_main_control_decode.sv | 77 +++++++
 rtl/mc_main_control.sv | 114 +++++++++++
 3 files changed

// File: rtl/mc_main_control_pkg.sv
// Shared encodings for the multi-cycle MIPS main control: states, opcodes, ALU commands, selects.
// ACCM_EN adds the two accumulate-from-memory states.
package mc_main_control_pkg;

  localparam int unsigned OPC_BITS   = 6;
  localparam int unsigned FN_BITS    = 6;
  localparam int unsigned ALUOP_BITS = 3;
  localparam int unsigned STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    INIT     = 4'd0,
    IF       = 4'd1,
    ID       = 4'd2,
    EX_R     = 4'd3,
    WB_R     = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_LW   = 4'd6,
    WB_LW    = 4'd7,
    MEM_SW   = 4'd8,
    EX_BEQ   = 4'd9,
    EX_J     = 4'd10,
    EX_ADDI  = 4'd11,
`ifdef ACCM_EN
    WB_I     = 4'd12,
    ACCM_MEM = 4'd13,
    ACCM_EX  = 4'd14
`else
    WB_I     = 4'd12
`endif
  } state_t;

  localparam logic [OPC_BITS-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_BITS-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_BITS-1:0] OP_SW    = 6'b101011;
  localparam logic [OPC_BITS-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPC_BITS-1:0] OP_J     = 6'b000010;
  localparam logic [OPC_BITS-1:0] OP_ADDI  = 6'b001000;

  localparam logic [FN_BITS-1:0] FUNCT_ACCM = 6'b111000;

  localparam logic [ALUOP_BITS-1:0] ALUOp_CMD_ADD   = 3'd0;
  localparam logic [ALUOP_BITS-1:0] ALUOp_CMD_SUB   = 3'd1;
  localparam logic [ALUOP_BITS-1:0] ALUOp_CMD_RTYPE = 3'd2;

  localparam logic [1:0] ALU_B_RT     = 2'b00;
  localparam logic [1:0] ALU_B_FOUR   = 2'b01;
  localparam logic [1:0] ALU_B_IMM    = 2'b10;
  localparam logic [1:0] ALU_B_IMM_SH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef struct packed {
    logic                  pc_write;
    logic                  pc_write_cond;
    logic [1:0]            pc_source;
    logic                  i_or_d;
    logic                  mem_read;
    logic                  mem_write;
    logic                  ir_write;
    logic                  reg_dst;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic                  alu_src_a_pc;
    logic [1:0]            alu_src_b;
    logic [ALUOP_BITS-1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/mc_main_control_decode.sv
// Moore output decode: current state (plus mem_ready during fetch) to datapath control vector.
// ACCM_EN adds decode for the accumulate states.
module mc_control_decode
  import mc_main_control_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl       = '0;
    ctrl.aluop = ALUOp_CMD_ADD;
    unique case (state)
      IF: begin
        // PC+4 and IR load commit only in the cycle the fetch completes
        ctrl.mem_read     = 1'b1;
        ctrl.ir_write     = mem_ready;
        ctrl.pc_write     = mem_ready;
        ctrl.alu_src_a_pc = 1'b1;
        ctrl.alu_src_b    = ALU_B_FOUR;
        ctrl.pc_source    = PC_SRC_ALU;
      end
      ID: begin
        ctrl.alu_src_a_pc = 1'b1;
        ctrl.alu_src_b    = ALU_B_IMM_SH;
      end
      EX_R: begin
        ctrl.aluop     = ALUOp_CMD_RTYPE;
        ctrl.alu_src_b = ALU_B_RT;
      end
      WB_R: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      MEM_ADDR: ctrl.alu_src_b = ALU_B_IMM;
      MEM_LW: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      WB_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      MEM_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      EX_BEQ: begin
        ctrl.aluop         = ALUOp_CMD_SUB;
        ctrl.alu_src_b     = ALU_B_RT;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
      end
      EX_J: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_JUMP;
      end
      EX_ADDI: ctrl.alu_src_b = ALU_B_IMM;
      WB_I:    ctrl.reg_write = 1'b1;
`ifdef ACCM_EN
      ACCM_MEM: begin
        // ALU decoder steers the address source to Rs for this access
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
        ctrl.aluop    = ALUOp_CMD_RTYPE;
      end
      ACCM_EX: begin
        ctrl.aluop     = ALUOp_CMD_RTYPE;
        ctrl.alu_src_b = ALU_B_RT;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control FSM: state register, next-state dispatch and output ports.
// Define ACCM_EN to build the accumulate-from-memory R-type path (ACCM_MEM/ACCM_EX).
module mc_main_control
  import mc_main_control_pkg::*;
#(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned FUNCT_W  = 6,
  parameter int unsigned ALUOP_W  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_source,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a_pc,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  aluop,
  output logic                illegal_instr,
  output logic [3:0]          state_o
);

  state_t state;
  state_t state_nxt;
  logic   illegal_c;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    illegal_c = 1'b0;
    unique case (state)
      INIT: state_nxt = IF;
      IF:   state_nxt = mem_ready ? ID : IF;
      ID: begin
        case (opcode)
          OPCODE_W'(OP_RTYPE): begin
`ifdef ACCM_EN
            state_nxt = (funct == FUNCT_W'(FUNCT_ACCM)) ? ACCM_MEM : EX_R;
`else
            state_nxt = EX_R;
`endif
          end
          OPCODE_W'(OP_LW),
          OPCODE_W'(OP_SW):   state_nxt = MEM_ADDR;
          OPCODE_W'(OP_BEQ):  state_nxt = EX_BEQ;
          OPCODE_W'(OP_J):    state_nxt = EX_J;
          OPCODE_W'(OP_ADDI): state_nxt = EX_ADDI;
          default: begin
            state_nxt = IF;
            illegal_c = 1'b1;
          end
        endcase
      end
      EX_R:     state_nxt = WB_R;
      WB_R:     state_nxt = IF;
      MEM_ADDR: state_nxt = (opcode == OPCODE_W'(OP_LW)) ? MEM_LW : MEM_SW;
      MEM_LW:   state_nxt = mem_ready ? WB_LW : MEM_LW;
      WB_LW:    state_nxt = IF;
      MEM_SW:   state_nxt = mem_ready ? IF : MEM_SW;
      EX_BEQ:   state_nxt = IF;
      EX_J:     state_nxt = IF;
      EX_ADDI:  state_nxt = WB_I;
      WB_I:     state_nxt = IF;
`ifdef ACCM_EN
      ACCM_MEM: state_nxt = mem_ready ? ACCM_EX : ACCM_MEM;
      ACCM_EX:  state_nxt = WB_R;
`endif
      default:  state_nxt = INIT;
    endcase
  end

`ifndef ACCM_EN
  // funct only matters for the accumulate dispatch
  logic funct_unused;
  assign funct_unused = ^funct;
`endif

  mc_control_decode u_decode (
    .state     (state),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_source     = ctrl.pc_source;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a_pc  = ctrl.alu_src_a_pc;
  assign alu_src_b     = ctrl.alu_src_b;
  assign aluop         = ALUOP_W'(ctrl.aluop);
  assign illegal_instr = illegal_c;
  assign state_o       = 4'(state);

endmodule
